addsub8_cla_reg: RTL and testbench

- Registered two's-complement adder/subtractor built from 2-bit carry-lookahead slices.
- The subtract path conditionally inverts b and injects the mode bit as carry-in.
- Result, carry-out and signed overflow are captured in output registers one clock after a valid request.
- Used as the arithmetic datapath element for small ALU stages.

---
 rtl/addsub_pkg.sv | 6 +
 rtl/cla2_slice.sv | 20 ++
 rtl/addsub8_cla_reg.sv | 66 ++++++
 tb/tb_addsub8_cla_reg.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/addsub_pkg.sv
// Shared constants for the registered CLA adder/subtractor.
package addsub_pkg;
    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;
    localparam int ADDSUB_WIDTH = 8;
endpackage

// File: rtl/cla2_slice.sv
// Two-bit carry-lookahead slice: both carries come straight from generate/propagate terms.
module cla2_slice (
    input  logic [1:0] a,
    input  logic [1:0] b,
    input  logic       cin,
    output logic [1:0] s,
    output logic [1:0] c
);
    logic [1:0] g;
    logic [1:0] p;

    assign g = a & b;
    assign p = a ^ b;

    assign c[0] = g[0] | (p[0] & cin);
    assign c[1] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);

    assign s[0] = p[0] ^ cin;
    assign s[1] = p[1] ^ c[0];
endmodule

// File: rtl/addsub8_cla_reg.sv
// Registered two's-complement add/subtract on chained 2-bit CLA slices.
// Define ADDSUB_STATUS_FLAGS_EN to add registered zero/neg status outputs.
module addsub8_cla_reg
    import addsub_pkg::*;
#(
    parameter int WIDTH = ADDSUB_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             m,
    output logic             out_valid,
    output logic [WIDTH-1:0] s,
    output logic             cout,
`ifdef ADDSUB_STATUS_FLAGS_EN
    output logic             zero,
    output logic             neg,
`endif
    output logic             ovr
);
    logic [WIDTH-1:0] bx;
    logic [WIDTH-1:0] sum;
    // carry[i] is the carry into bit i; carry[WIDTH] is the MSB carry out.
    logic [WIDTH:0]   carry;

    assign bx       = b ^ {WIDTH{m}};
    assign carry[0] = m;

    generate
        for (genvar gi = 0; gi < WIDTH / 2; gi++) begin : g_slice
            cla2_slice u_slice (
                .a   (a[2*gi+1 -: 2]),
                .b   (bx[2*gi+1 -: 2]),
                .cin (carry[2*gi]),
                .s   (sum[2*gi+1 -: 2]),
                .c   (carry[2*gi+2 -: 2])
            );
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            s         <= '0;
            cout      <= 1'b0;
            ovr       <= 1'b0;
`ifdef ADDSUB_STATUS_FLAGS_EN
            zero      <= 1'b0;
            neg       <= 1'b0;
`endif
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                s    <= sum;
                cout <= carry[WIDTH];
                ovr  <= carry[WIDTH-1] ^ carry[WIDTH];
`ifdef ADDSUB_STATUS_FLAGS_EN
                zero <= (sum == '0);
                neg  <= sum[WIDTH-1];
`endif
            end
        end
    end
endmodule

// File: tb/tb_addsub8_cla_reg.sv
// Self-checking bench for addsub8_cla_reg: directed vector table, hand sequences, random vs integer model.
module tb_addsub8_cla_reg;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic [7:0] a;
    logic [7:0] b;
    logic       m;
    logic       out_valid;
    logic [7:0] s;
    logic       cout;
    logic       ovr;
`ifdef ADDSUB_STATUS_FLAGS_EN
    logic       zero;
    logic       neg;
`endif

    always #5 clk = ~clk;

    addsub8_cla_reg #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .m         (m),
        .out_valid (out_valid),
        .s         (s),
        .cout      (cout),
`ifdef ADDSUB_STATUS_FLAGS_EN
        .zero      (zero),
        .neg       (neg),
`endif
        .ovr       (ovr)
    );

    int total = 0;
    int bad   = 0;

    // Reference state: what the output registers should hold.
    logic       exp_valid;
    logic [7:0] exp_s;
    logic       exp_cout;
    logic       exp_ovr;

    typedef struct {
        logic [7:0] va;
        logic [7:0] vb;
        logic       vm;
        logic [7:0] vs;
        logic       vcout;
        logic       vovr;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", name, got, want);
        end
    endtask

    // Arithmetic-level model: signed/unsigned integer results, no carry chain.
    task automatic model(input logic r, input logic v, input logic [7:0] ta,
                         input logic [7:0] tb2, input logic tm);
        int ua, ub, sa, sb, res;
        if (!r) begin
            exp_valid = 1'b0;
            exp_s     = 8'h00;
            exp_cout  = 1'b0;
            exp_ovr   = 1'b0;
        end else begin
            exp_valid = v;
            if (v) begin
                ua  = int'(ta);
                ub  = int'(tb2);
                sa  = int'($signed(ta));
                sb  = int'($signed(tb2));
                res = tm ? (sa - sb) : (sa + sb);
                exp_s    = 8'(res);
                exp_ovr  = (res > 127) || (res < -128);
                exp_cout = tm ? (ua >= ub) : (ua + ub > 255);
            end
        end
    endtask

    task automatic step(input logic r, input logic v, input logic [7:0] ta,
                        input logic [7:0] tb2, input logic tm, input string tag);
        rst_n    = r;
        in_valid = v;
        a        = ta;
        b        = tb2;
        m        = tm;
        @(posedge clk);
        model(r, v, ta, tb2, tm);
        @(negedge clk);
        $display("%s rst_n=%0b v=%0b a=%02h b=%02h m=%0b -> ov=%0b s=%02h c=%0b o=%0b",
                 tag, r, v, ta, tb2, tm, out_valid, s, cout, ovr);
        chk({tag, ".out_valid"}, 32'(out_valid), 32'(exp_valid));
        chk({tag, ".s"},         32'(s),         32'(exp_s));
        chk({tag, ".cout"},      32'(cout),      32'(exp_cout));
        chk({tag, ".ovr"},       32'(ovr),       32'(exp_ovr));
`ifdef ADDSUB_STATUS_FLAGS_EN
        chk({tag, ".zero"},      32'(zero),      32'(exp_s == 8'h00));
        chk({tag, ".neg"},       32'(neg),       32'(exp_s[7]));
`endif
    endtask

    initial begin
        vecs[0] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[1] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
        vecs[2] = '{8'h55, 8'hAA, 1'b0, 8'hFF, 1'b0, 1'b0};
        vecs[3] = '{8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1};
        vecs[4] = '{8'h6C, 8'hCA, 1'b1, 8'hA2, 1'b0, 1'b1};
        vecs[5] = '{8'h05, 8'h80, 1'b1, 8'h85, 1'b0, 1'b1};

        rst_n = 1'b0; in_valid = 1'b1; a = 8'h3C; b = 8'h5A; m = 1'b0;
        @(negedge clk);

        // Reset held two cycles with in_valid asserted
        step(1'b0, 1'b1, 8'h3C, 8'h5A, 1'b0, "reset0");
        step(1'b0, 1'b1, 8'hFF, 8'hFF, 1'b1, "reset1");

        // Directed table, back-to-back
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 1'b1, vecs[i].va, vecs[i].vb, vecs[i].vm, $sformatf("vec%0d", i));
            chk($sformatf("vec%0d.tbl_s", i),    32'(s),    32'(vecs[i].vs));
            chk($sformatf("vec%0d.tbl_cout", i), 32'(cout), 32'(vecs[i].vcout));
            chk($sformatf("vec%0d.tbl_ovr", i),  32'(ovr),  32'(vecs[i].vovr));
        end

        // Hold: idle cycle keeps last result, out_valid drops
        step(1'b1, 1'b1, 8'h12, 8'h34, 1'b0, "hold_load");
        step(1'b1, 1'b0, 8'hEE, 8'h01, 1'b1, "hold_idle");
        chk("hold.s_kept", 32'(s), 32'h46);
        step(1'b1, 1'b1, 8'h00, 8'h00, 1'b1, "hold_resume");

        // Mid-stream reset discards in-flight result
        step(1'b1, 1'b1, 8'h40, 8'h40, 1'b0, "mid_a");
        step(1'b0, 1'b1, 8'h33, 8'h11, 1'b0, "mid_rst");
        step(1'b1, 1'b1, 8'h33, 8'h11, 1'b1, "mid_fresh");

        // Random streaming with occasional idle and reset cycles
        for (int i = 0; i < 300; i++) begin
            logic r, v, tm;
            logic [7:0] ta, tb2;
            r   = ($urandom_range(0, 39) != 0);
            v   = ($urandom_range(0, 4) != 0);
            tm  = 1'($urandom);
            ta  = 8'($urandom);
            tb2 = 8'($urandom);
            step(r, v, ta, tb2, tm, $sformatf("rnd%0d", i));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
